// File: rtl/serial_frame_decode.sv
// Serial frame decoder: hunts for a sync word within a Hamming tolerance, then captures a fixed-length payload.
// The payload is presented in a held output register under a valid/ack handshake; stalled captures time out.
module serial_frame_decode #(
    parameter int                   SYNC_BITS      = 96,
    parameter logic [SYNC_BITS-1:0] SYNC_PATTERN   = '0,
    parameter int                   MAX_MISMATCH   = 0,
    parameter int                   PAYLOAD_BITS   = 96,
    parameter int                   EDGE_MODE      = 0,
    parameter int                   TIMEOUT_CYCLES = 4096
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    serial_data,
    input  logic                    serial_clock,
    output logic [PAYLOAD_BITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ack,
    output logic                    sync_lock,
    output logic [2:0]              sync_errors,
    output logic                    overrun,
    output logic                    abort
);
    localparam int FILL_W = $clog2(SYNC_BITS + 1);
    localparam int CNT_W  = $clog2(PAYLOAD_BITS + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        MM_LIMIT  = 8'(MAX_MISMATCH);

    typedef enum logic {HUNT, CAPTURE} state_t;

    state_t                  state_q, state_d;
    logic                    prev_q, prev_d;
    logic [SYNC_BITS-1:0]    window_q, window_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [CNT_W-1:0]        bitcnt_q, bitcnt_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic [PAYLOAD_BITS-1:0] frame_data_q, frame_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic [2:0]              sync_errors_q, sync_errors_d;
    logic                    overrun_q, overrun_d;
    logic                    abort_q, abort_d;

    logic                    strobe;
    logic [SYNC_BITS-1:0]    diff;
    logic [7:0]              pop;
    logic                    match;
    logic                    complete;
    logic                    ack_eff;
    logic [PAYLOAD_BITS-1:0] shifted;

    assign strobe  = (EDGE_MODE != 0) ? (serial_clock & ~prev_q) : serial_clock;
    assign diff    = window_q ^ SYNC_PATTERN;
    assign shifted = {shreg_q[PAYLOAD_BITS-2:0], serial_data};
    assign ack_eff = frame_ack & frame_valid_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < SYNC_BITS; i++) begin
            pop = pop + {7'd0, diff[i]};
        end
    end

    // Match looks at the window as it stood before this strobe, so the bit arriving now is payload bit 0.
    assign match = (fill_q == FILL_FULL) && (pop <= MM_LIMIT);

    always_comb begin
        state_d       = state_q;
        prev_d        = serial_clock;
        window_d      = window_q;
        fill_d        = fill_q;
        bitcnt_d      = bitcnt_q;
        timer_d       = timer_q;
        shreg_d       = shreg_q;
        sync_errors_d = sync_errors_q;
        abort_d       = 1'b0;
        complete      = 1'b0;

        case (state_q)
            HUNT: begin
                timer_d = '0;
                if (strobe) begin
                    if (match) begin
                        state_d       = CAPTURE;
                        bitcnt_d      = CNT_W'(1);
                        sync_errors_d = pop[2:0];
                        shreg_d       = shifted;
                        window_d      = '0;
                        fill_d        = '0;
                    end else begin
                        window_d = {window_q[SYNC_BITS-2:0], serial_data};
                        if (fill_q != FILL_FULL) begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                    end
                end
            end
            CAPTURE: begin
                if (strobe) begin
                    shreg_d  = shifted;
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    timer_d  = '0;
                    if (bitcnt_q == CNT_LAST) begin
                        complete = 1'b1;
                        state_d  = HUNT;
                        bitcnt_d = '0;
                    end
                end else if (timer_q == TMR_LAST) begin
                    abort_d  = 1'b1;
                    state_d  = HUNT;
                    bitcnt_d = '0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // A completing frame may replace the held one only if the slot is empty or being acked this cycle.
    always_comb begin
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        if (complete) begin
            if (!frame_valid_q || ack_eff) begin
                frame_data_d  = shifted;
                frame_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ack_eff) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            prev_q        <= 1'b0;
            window_q      <= '0;
            fill_q        <= '0;
            bitcnt_q      <= '0;
            timer_q       <= '0;
            shreg_q       <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            sync_errors_q <= '0;
            overrun_q     <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            window_q      <= window_d;
            fill_q        <= fill_d;
            bitcnt_q      <= bitcnt_d;
            timer_q       <= timer_d;
            shreg_q       <= shreg_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            sync_errors_q <= sync_errors_d;
            overrun_q     <= overrun_d;
            abort_q       <= abort_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign sync_lock   = (state_q == CAPTURE);
    assign sync_errors = sync_errors_q;
    assign overrun     = overrun_q;
    assign abort       = abort_q;
endmodule
